// File: rtl/byte_serial_adder_pkg.sv
// Shared types and helpers for the byte-serial add/subtract engine.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the byte index counter; never narrower than one bit.
  function automatic int idx_w(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/byte_serial_adder_cselect_add8_ci.sv
// Combinational 8-bit carry-select adder slice with carry-in.
// Each nibble is computed for both possible carry-ins; the real carry picks one.
module cselect_add8_ci
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              c7
);

  // 4-bit ripple add, returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[4], s};
  endfunction

  logic [4:0] lo0, lo1, hi0, hi1, lo, hi;

  assign lo0 = ripple4(a[3:0], b[3:0], 1'b0);
  assign lo1 = ripple4(a[3:0], b[3:0], 1'b1);
  assign hi0 = ripple4(a[7:4], b[7:4], 1'b0);
  assign hi1 = ripple4(a[7:4], b[7:4], 1'b1);

  assign lo   = cin   ? lo1 : lo0;
  assign hi   = lo[4] ? hi1 : hi0;

  assign sum  = {hi[3:0], lo[3:0]};
  assign cout = hi[4];
  // Carry into bit 7 recovered from the bit-7 sum: s7 = a7 ^ b7 ^ c7.
  assign c7   = a[7] ^ b[7] ^ hi[3];

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial NBYTES-wide add/subtract engine built around one 8-bit
// carry-select slice. One operation in flight; valid/ready on both sides.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_w(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_t            state, state_nxt;
  logic [W-1:0]      a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg, ovf_reg;
  logic [IDX_W-1:0]  idx;
  logic              accept, step, last;
  logic [BYTE_W-1:0] slice_sum;
  logic              slice_cout, slice_c7;

  assign accept = (state == IDLE) && in_valid;
  assign step   = (state == RUN);
  assign last   = (idx == LAST);

  cselect_add8_ci u_slice (
    .a    (a_reg[BYTE_W-1:0]),
    .b    (b_reg[BYTE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c7   (slice_c7)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, step bytes in RUN, hold result in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry chain between bytes and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b ^ {W{sub}};
      sum_reg   <= '0;
      carry_reg <= sub;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else if (step) begin
      a_reg     <= a_reg >> BYTE_W;
      b_reg     <= b_reg >> BYTE_W;
      sum_reg   <= {slice_sum, sum_reg[W-1:BYTE_W]};
      carry_reg <= slice_cout;
      idx       <= idx + IDX_W'(1);
      if (last) begin
        cout_reg <= slice_cout;
        ovf_reg  <= slice_c7 ^ slice_cout;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder at NBYTES=4 and NBYTES=2.
module tb_byte_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [31:0] a4, b4, sum4;
  logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [15:0] a2, b2, sum2;

  byte_serial_adder #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  byte_serial_adder #(.NBYTES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  exp_t q4[$];
  exp_t q2[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   rnd_ready = 1'b0;
  logic force4 = 1'b1;
  logic force2 = 1'b1;
  time  last_acc;
  bit   have_last = 1'b0;

  // Reference: plain wide arithmetic on the effective operands.
  function automatic exp_t model(input int nb, input logic [31:0] A, input logic [31:0] B,
                                 input logic s);
    exp_t e;
    logic [63:0] mask, aa, bb, full;
    int w;
    w    = 8 * nb;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, A} & mask;
    bb   = {32'd0, (s ? ~B : B)} & mask;
    full = aa + bb + {63'd0, s};
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return e;
  endfunction

  // out_ready driver: random or forced level, updated just after each edge.
  initial begin
    out_ready4 = 1'b1;
    out_ready2 = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready4 = rnd_ready ? 1'($urandom_range(0, 1)) : force4;
      out_ready2 = rnd_ready ? 1'($urandom_range(0, 1)) : force2;
    end
  end

  // Monitor for the 4-byte instance.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result4 got sum=%h with no operation outstanding", sum4);
      end else begin
        e = q4.pop_front();
        vectors++;
        if ({sum4, cout4, ovf4} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result4 got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum4, cout4, ovf4, e.sum, e.cout, e.ovf);
        end
      end
    end
    if (in_ready4 && out_valid4) begin
      errors++;
      $display("FAIL handshake4 got in_ready=1 out_valid=1 expected not both");
    end
  end

  // Monitor for the 2-byte instance.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result2 got sum=%h with no operation outstanding", sum2);
      end else begin
        e = q2.pop_front();
        vectors++;
        if ({16'd0, sum2, cout2, ovf2} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result2 got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum2, cout2, ovf2, e.sum[15:0], e.cout, e.ovf);
        end
      end
    end
    if (in_ready2 && out_valid2) begin
      errors++;
      $display("FAIL handshake2 got in_ready=1 out_valid=1 expected not both");
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Issue one operation, push its expectation, and check accept-to-valid latency.
  task automatic send(input int nb, input logic [31:0] A, input logic [31:0] B,
                      input logic s, input bit chk_tput);
    int  waited;
    int  lat;
    bit  seen;
    bit  rdy;
    time t;
    waited = 0;
    rdy    = 1'b0;
    while (!rdy && waited < 1000) begin
      @(negedge clk);
      rdy = (nb == 4) ? in_ready4 : in_ready2;
      waited++;
    end
    if (!rdy) begin
      errors++;
      $display("FAIL in_ready_timeout nb=%0d got in_ready=0 expected 1", nb);
      return;
    end
    if (nb == 4) begin
      in_valid4 = 1'b1; a4 = A; b4 = B; sub4 = s;
      q4.push_back(model(4, A, B, s));
    end else begin
      in_valid2 = 1'b1; a2 = A[15:0]; b2 = B[15:0]; sub2 = s;
      q2.push_back(model(2, A, B, s));
    end
    @(posedge clk);
    t = $time;
    if (chk_tput && have_last)
      check("throughput_spacing", 64'((t - last_acc) / 10), 64'(nb + 2));
    last_acc  = t;
    have_last = 1'b1;
    #1;
    in_valid4 = 1'b0;
    in_valid2 = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= nb + 2 && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((nb == 4) ? out_valid4 : out_valid2) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("latency", 64'(seen ? lat : -1), 64'(nb));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q2.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d/%0d outstanding expected 0", q4.size(), q2.size());
    end
  endtask

  initial begin : stim
    logic [31:0] held;
    bit          early;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset4", {in_ready4, out_valid4, sum4, cout4, ovf4}, {1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    check("reset2", {in_ready2, out_valid2, sum2, cout2, ovf2}, {1'b1, 1'b0, 16'd0, 1'b0, 1'b0});
    rst = 1'b0;

    // Directed corner cases.
    send(4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(4, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    send(4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(4, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    send(2, 32'h0000_7FFF, 32'h0000_8000, 1'b1, 1'b0);
    drain();

    // Backpressure: result must hold and new requests must be ignored.
    force4 = 1'b0;
    repeat (2) @(posedge clk);
    send(4, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    held = sum4;
    check("bp_sum_value", {32'd0, held}, 64'h0000_0000_0001_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid4, in_ready4, sum4}, {1'b1, 1'b0, held});
      in_valid4 = 1'b1;
      a4 = $urandom;
      b4 = $urandom;
      sub4 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    force4 = 1'b1;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    check("bp_release", {in_ready4, out_valid4, sum4}, {1'b1, 1'b0, held});
    drain();

    // Reset while the third byte is pending.
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 32'hDEAD_BEEF; b4 = 32'h0123_4567; sub4 = 1'b0;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_state", {in_ready4, out_valid4, sum4, cout4, ovf4},
          {1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    early = out_valid4;
    rst = 1'b0;
    send(4, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    check("abort_no_valid", {63'd0, early}, 64'd0);
    drain();

    // Random regression with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) send(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 1000; i++) send(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Throughput with out_ready held high.
    rnd_ready = 1'b0;
    force4 = 1'b1;
    force2 = 1'b1;
    repeat (3) @(posedge clk);
    have_last = 1'b0;
    for (int i = 0; i < 20; i++) send(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    have_last = 1'b0;
    for (int i = 0; i < 20; i++) send(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
